// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register-file geometry and types shared with the datapath
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; pointer moves past the winner on advance
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] N_EXT = (PW+1)'(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   pos;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= N_EXT) pos = pos - N_EXT;
      idx = pos[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port among writeback
// requesters; registered write stage plus read-after-write hazard flags for decode
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         Write_register,
  output logic [DATA_W-1:0]         Write_data,
  input  logic [ADDR_W-1:0]         rd_addr_1,
  input  logic [ADDR_W-1:0]         rd_addr_2,
  output logic                      hazard_1,
  output logic                      hazard_2
);

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] fire;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               pend_1;
  logic               pend_2;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (transfer),
    .grant   (grant)
  );

  assign req_ready = rst ? '0 : grant;
  assign fire      = req_valid & req_ready;
  assign transfer  = |fire;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fire[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Register 0 writes are consumed but never enabled, keeping $zero at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
    end else if (transfer) begin
      RegWrite       <= (sel_addr != '0);
      Write_register <= sel_addr;
      Write_data     <= sel_data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  // A write is pending if it sits in the output stage or is waiting at a requester.
  always_comb begin
    pend_1 = RegWrite && (Write_register == rd_addr_1);
    pend_2 = RegWrite && (Write_register == rd_addr_2);
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_1 = pend_1 | (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == rd_addr_1));
      pend_2 = pend_2 | (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == rd_addr_2));
    end
  end

  assign hazard_1 = (rd_addr_1 != '0) && pend_1;
  assign hazard_2 = (rd_addr_2 != '0) && pend_2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         Write_register;
  logic [DATA_W-1:0]         Write_data;
  logic [ADDR_W-1:0]         rd_addr_1;
  logic [ADDR_W-1:0]         rd_addr_2;
  logic                      hazard_1;
  logic                      hazard_2;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data),
    .rd_addr_1      (rd_addr_1),
    .rd_addr_2      (rd_addr_2),
    .hazard_1       (hazard_1),
    .hazard_2       (hazard_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  logic [DATA_W-1:0] d0 [0:1];
  logic [DATA_W-1:0] d1 [0:1];
  int n0;
  int n1;

  initial begin
    rst       = 1'b1;
    req_valid = 2'b11;
    req_addr  = '0;
    req_data  = '0;
    rd_addr_1 = '0;
    rd_addr_2 = '0;
    set_req(0, 5'd1, 32'h1111);
    set_req(1, 5'd2, 32'h2222);

    // reset held for two edges with both requesters valid
    tick();
    tick();
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_regwrite", 64'(RegWrite), 64'h0);
    check("rst_wreg", 64'(Write_register), 64'h0);
    check("rst_wdata", 64'(Write_data), 64'h0);

    rst       = 1'b0;
    req_valid = 2'b00;
    tick();

    // single request from requester 0
    req_valid = 2'b01;
    set_req(0, 5'd5, 32'hDEADBEEF);
    rd_addr_1 = 5'd5;
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'h1);
    check("single_haz_pending", 64'(hazard_1), 64'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("single_regwrite", 64'(RegWrite), 64'h1);
    check("single_wreg", 64'(Write_register), 64'd5);
    check("single_wdata", 64'(Write_data), 64'hDEADBEEF);
    check("single_haz_stage", 64'(hazard_1), 64'h1);
    tick();
    check("single_regwrite_drop", 64'(RegWrite), 64'h0);
    check("single_wreg_hold", 64'(Write_register), 64'd5);
    check("single_haz_clear", 64'(hazard_1), 64'h0);
    rd_addr_1 = '0;

    // write to $zero from requester 1; pointer is at 1 and wraps to 0
    req_valid = 2'b10;
    set_req(1, 5'd0, 32'h1234);
    @(negedge clk);
    check("zero_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    #1;
    check("zero_regwrite", 64'(RegWrite), 64'h0);
    check("zero_wdata", 64'(Write_data), 64'h1234);

    // both requesters stay valid for four cycles: grants 0,1,0,1
    d0[0] = 32'hA0000000; d0[1] = 32'hA0000001;
    d1[0] = 32'hB0000000; d1[1] = 32'hB0000001;
    n0 = 0;
    n1 = 0;
    set_req(0, 5'd10, d0[0]);
    set_req(1, 5'd11, d1[0]);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr_ready_%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      check($sformatf("rr_regwrite_%0d", k), 64'(RegWrite), 64'h1);
      if (k % 2 == 0) begin
        check($sformatf("rr_wreg_%0d", k), 64'(Write_register), 64'd10);
        check($sformatf("rr_wdata_%0d", k), 64'(Write_data), 64'(d0[n0]));
        n0++;
        if (n0 < 2) set_req(0, 5'd10, d0[n0]);
      end else begin
        check($sformatf("rr_wreg_%0d", k), 64'(Write_register), 64'd11);
        check($sformatf("rr_wdata_%0d", k), 64'(Write_data), 64'(d1[n1]));
        n1++;
        if (n1 < 2) set_req(1, 5'd11, d1[n1]);
      end
    end
    req_valid = 2'b00;
    tick();

    // hazards: pending requester address, then output-stage address
    req_valid = 2'b10;
    set_req(1, 5'd7, 32'h77);
    rd_addr_1 = 5'd7;
    rd_addr_2 = 5'd0;
    @(negedge clk);
    check("haz1_pending", 64'(hazard_1), 64'h1);
    check("haz2_zero_addr", 64'(hazard_2), 64'h0);
    rd_addr_1 = 5'd0;
    #1;
    check("haz1_zero_addr", 64'(hazard_1), 64'h0);
    tick();
    req_valid = 2'b01;
    set_req(0, 5'd9, 32'h99);
    rd_addr_1 = 5'd0;
    rd_addr_2 = 5'd8;
    tick();
    req_valid = 2'b00;
    rd_addr_2 = 5'd9;
    #1;
    check("haz2_stage", 64'(hazard_2), 64'h1);
    rd_addr_2 = 5'd8;
    #1;
    check("haz2_other", 64'(hazard_2), 64'h0);
    rd_addr_2 = 5'd9;
    tick();
    check("haz2_stale", 64'(hazard_2), 64'h0);
    rd_addr_2 = 5'd0;

    // same destination from both: pointer at 1, so r1 then r0; r0's data lands last
    req_valid = 2'b11;
    set_req(0, 5'd12, 32'h111);
    set_req(1, 5'd12, 32'h222);
    @(negedge clk);
    check("same_ready_a", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b01;
    #1;
    check("same_wdata_a", 64'(Write_data), 64'h222);
    @(negedge clk);
    check("same_ready_b", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("same_wdata_b", 64'(Write_data), 64'h111);
    check("same_wreg_b", 64'(Write_register), 64'd12);

    // reset mid-operation: in-flight write to reg 3 is dropped, pointer returns to 0
    req_valid = 2'b01;
    set_req(0, 5'd3, 32'h33);
    tick();
    check("midrst_inflight", 64'(RegWrite), 64'h1);
    rst       = 1'b1;
    req_valid = 2'b11;
    set_req(1, 5'd4, 32'h44);
    #1;
    check("midrst_ready", 64'(req_ready), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_regwrite", 64'(RegWrite), 64'h0);
    check("midrst_ptr", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
